// File: rtl/sipo_deserializer_pkg.sv
// Shared definitions for the SIPO deserializer slice.
// Contents: FSM state encoding, bit-slice mux selects, byte/counter widths.
package sipo_deserializer_pkg;

  localparam int          BYTE_W   = 8;
  localparam int          CNT_W    = 3;
  localparam logic [2:0]  LAST_CNT = 3'd7;

  // 2-bit state register; 11 is unreachable and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SHIFT   = 2'b01,
    ST_DONE    = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_t;

  // Mux select for one S2 bit slice.
  typedef enum logic [1:0] {
    CELL_HOLD  = 2'b00,
    CELL_TAKE  = 2'b01,
    CELL_CLEAR = 2'b10
  } cell_sel_t;

endpackage

// File: rtl/sipo_deserializer_if.sv
// Handshake/data bundle between a serial source and the deserializer.
// Signals: start, sin (source -> deserializer); out[7:0], valid, busy
// (deserializer -> source/holding register).
// Modports: master = serial source side, slave = deserializer side.
interface sipo_deserializer_if;
  import sipo_deserializer_pkg::*;

  logic              start;
  logic              sin;
  logic [BYTE_W-1:0] out;
  logic              valid;
  logic              busy;

  modport master (output start, output sin, input out, input valid, input busy);
  modport slave  (input start, input sin, output out, output valid, output busy);

endinterface

// File: rtl/sipo_shift_cell.sv
// One bit slice of the deserializer: an S2 flop with a 3-way input mux.
// Ports: clk, rst (async, active-high), sel (hold / take d / clear),
//        d (neighbour bit or assembled bit), q (stored bit).
module sipo_shift_cell
  import sipo_deserializer_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  cell_sel_t sel,
  input  logic      d,
  output logic      q
);

  // NOTE: flops are written with non-blocking assignments so every slice
  // samples its neighbour's value from before the edge, making the chain shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case (sel)
        CELL_TAKE:  q <= d;
        CELL_CLEAR: q <= 1'b0;
        default:    q <= q;
      endcase
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: after a start request, collects 8
// serial bits, loads the complete byte onto out and strobes valid for one
// cycle. out changes only when a byte completes.
// Ports: clk, rst (async, active-high), bus (slave modport: start, sin in;
//        out[7:0], valid, busy out).
// Parameter LSB_FIRST: 1 = first received bit lands in out[0], 0 = out[7].
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  sipo_deserializer_if.slave  bus
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [BYTE_W-1:0] sr;
  logic [BYTE_W-1:0] sr_d;
  logic [BYTE_W-1:0] out_q;
  cell_sel_t         sr_sel;
  cell_sel_t         out_sel;
  logic              in_shift;
  logic              in_done;
  logic              last_bit;
  logic              accept;

  // Ripple incrementer from half-adder cells; 7 wraps to 0 on its own.
  assign cnt_inc = {cnt[2] ^ (cnt[1] & cnt[0]), cnt[1] ^ cnt[0], ~cnt[0]};

  assign in_shift = (state == ST_SHIFT);
  assign in_done  = (state == ST_DONE);
  assign last_bit = in_shift && (cnt == LAST_CNT);
  // start is only honoured from IDLE or DONE; it is ignored mid-byte.
  assign accept   = bus.start && ((state == ST_IDLE) || in_done);

  // NOTE: every signal driven here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sr_sel  = CELL_HOLD;
    out_sel = CELL_HOLD;
    if (in_shift) begin
      sr_sel = CELL_TAKE;
    end else if (accept) begin
      sr_sel = CELL_CLEAR;
    end
    if (last_bit) begin
      out_sel = CELL_TAKE;
    end
  end

  // Shift direction: LSB-first shifts right with sin entering bit 7, so the
  // first bit ends at bit 0 after eight shifts; MSB-first mirrors that.
  // sr_d is the word after this edge's shift, which is also what out loads
  // on the last bit, so the 8th bit is included without an extra cycle.
  for (genvar i = 0; i < BYTE_W; i++) begin : g_bit
    if (LSB_FIRST) begin : g_lsb
      if (i == BYTE_W - 1) begin : g_end
        assign sr_d[i] = bus.sin;
      end else begin : g_mid
        assign sr_d[i] = sr[i+1];
      end
    end else begin : g_msb
      if (i == 0) begin : g_end
        assign sr_d[i] = bus.sin;
      end else begin : g_mid
        assign sr_d[i] = sr[i-1];
      end
    end

    sipo_shift_cell u_sr_cell (
      .clk (clk),
      .rst (rst),
      .sel (sr_sel),
      .d   (sr_d[i]),
      .q   (sr[i])
    );

    sipo_shift_cell u_out_cell (
      .clk (clk),
      .rst (rst),
      .sel (out_sel),
      .d   (sr_d[i]),
      .q   (out_q[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state <= ST_SHIFT;
            cnt   <= '0;
          end
        end
        ST_SHIFT: begin
          cnt <= cnt_inc;
          if (cnt == LAST_CNT) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          cnt   <= '0;
          state <= bus.start ? ST_SHIFT : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Outputs depend on state and flops only; the unused encoding reads as IDLE.
  assign bus.out   = out_q;
  assign bus.valid = in_done;
  assign bus.busy  = in_shift || in_done;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer: one LSB-first and one MSB-first
// instance receive identical serial stimulus; expected bytes are constants.
module tb_sipo_deserializer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   cyc;
  int   done_cyc;
  int   t_first;
  logic [7:0] last_l;
  logic [7:0] last_m;

  sipo_deserializer_if lbus ();
  sipo_deserializer_if mbus ();

  sipo_deserializer #(.LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst(rst), .bus(lbus));
  sipo_deserializer #(.LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(mbus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [7:0] exp_l, input logic [7:0] exp_m,
                            input logic exp_valid, input logic exp_busy);
    check({tag, ".out_lsb"},   lbus.out,   exp_l);
    check({tag, ".out_msb"},   mbus.out,   exp_m);
    check({tag, ".valid_lsb"}, lbus.valid, exp_valid);
    check({tag, ".valid_msb"}, mbus.valid, exp_valid);
    check({tag, ".busy_lsb"},  lbus.busy,  exp_busy);
    check({tag, ".busy_msb"},  mbus.busy,  exp_busy);
  endtask

  task automatic drive(input logic st, input logic s);
    lbus.start = st;
    lbus.sin   = s;
    mbus.start = st;
    mbus.sin   = s;
  endtask

  // Called at a falling edge; advances one rising edge, returns at the next falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Edges E1..E8 of one byte; seq[0] is sent first. pulse_k puts a stray
  // start on the edge for seq[pulse_k]. Ends in the DONE cycle.
  task automatic shift_bits(input logic [7:0] seq, input logic hold, input int pulse_k,
                            input logic [7:0] exp_l, input logic [7:0] exp_m);
    for (int k = 0; k < 8; k++) begin
      drive(hold || (k == pulse_k), seq[k]);
      tick();
      if (k < 7) begin
        check_outs("shift", last_l, last_m, 1'b0, 1'b1);
      end else begin
        last_l = exp_l;
        last_m = exp_m;
        check_outs("done", last_l, last_m, 1'b1, 1'b1);
        done_cyc = cyc;
      end
    end
  endtask

  task automatic start_byte();
    drive(1'b1, 1'b0);
    tick();
    check_outs("e0", last_l, last_m, 1'b0, 1'b1);
  endtask

  task automatic go_idle(input string tag);
    drive(1'b0, 1'b0);
    tick();
    check_outs(tag, last_l, last_m, 1'b0, 1'b0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    last_l = 8'h00;
    last_m = 8'h00;
    rst    = 1'b0;
    drive(1'b0, 1'b0);

    // Asynchronous reset before any clock edge has occurred.
    #2 rst = 1'b1;
    #1 check_outs("async_rst", 8'h00, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_outs("idle_hold", 8'h00, 8'h00, 1'b0, 1'b0);
    end

    // 1,0,1,0,0,1,0,1 -> A5 either order (palindrome).
    start_byte();
    shift_bits(8'hA5, 1'b0, -1, 8'hA5, 8'hA5);
    go_idle("after_a5");

    // 1,1,0,0,0,0,0,0 -> 03 LSB-first, C0 MSB-first.
    start_byte();
    shift_bits(8'h03, 1'b0, -1, 8'h03, 8'hC0);
    go_idle("after_03");

    // Back-to-back with start held high: 3C then FF, valid 9 cycles apart.
    start_byte();
    shift_bits(8'h3C, 1'b1, -1, 8'h3C, 8'h3C);
    t_first = done_cyc;
    drive(1'b1, 1'b0);
    tick();
    check_outs("b2b_no_idle", 8'h3C, 8'h3C, 1'b0, 1'b1);
    shift_bits(8'hFF, 1'b1, -1, 8'hFF, 8'hFF);
    check("b2b_valid_spacing", done_cyc - t_first, 9);
    go_idle("after_b2b");

    // Stray start at E3 is ignored; out holds while sin toggles in IDLE.
    // 0,1,1,1,1,0,0,0 -> 1E LSB-first, 78 MSB-first.
    start_byte();
    shift_bits(8'h1E, 1'b0, 2, 8'h1E, 8'h78);
    go_idle("after_1e");
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, i[0]);
      tick();
      check_outs("idle_sin_toggle", 8'h1E, 8'h78, 1'b0, 1'b0);
    end

    // Reset after four bits of an aborted byte, then a fresh 81.
    start_byte();
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b1);
      tick();
    end
    #2 rst = 1'b1;
    #1 check_outs("mid_rst", 8'h00, 8'h00, 1'b0, 1'b0);
    last_l = 8'h00;
    last_m = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    go_idle("post_rst_idle");
    start_byte();
    shift_bits(8'h81, 1'b0, -1, 8'h81, 8'h81);
    go_idle("after_81");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
